dmem_access_seq: RTL and testbench

//  Multi-cycle controller that turns 32-bit load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW)

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_access_seq_load_ext.sv | 29 ++
 rtl/dmem_access_seq.sv | 135 +++++++++++++
 tb/tb_dmem_access_seq.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-serial data memory access sequencer.
// Holds the size encoding, FSM states and the byte-count helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Number of byte cycles an access of the given size takes.
    // The illegal encoding never reaches ACCESS, so its value is irrelevant.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_B:    nbytes = 3'd1;
            SZ_H:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_seq_load_ext.sv
// Combinational load-data extender: sign- or zero-extends byte and half loads,
// passes word loads through unchanged.
module load_ext
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      size,
    input  logic            zero_ext,
    output logic [XLEN-1:0] result
);

    logic byte_fill;
    logic half_fill;

    assign byte_fill = ~zero_ext & rdata[7];
    assign half_fill = ~zero_ext & rdata[15];

    always_comb begin
        result = rdata;
        case (size)
            SZ_B:    result = {{(XLEN-8){byte_fill}}, rdata[7:0]};
            SZ_H:    result = {{(XLEN-16){half_fill}}, rdata[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_seq.sv
// Multi-cycle controller that serialises 32-bit load/store requests into
// little-endian byte accesses on an 8-bit data memory and returns one response beat.
module dmem_access_seq
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_wd,
    output logic              mem_we,
    input  logic [7:0]        mem_rd
);

    state_e            state_q;
    state_e            state_d;
    logic [1:0]        idx_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   ext_rdata;
    logic              last_byte;

    assign last_byte = ({1'b0, idx_q} == (nbytes(size_q) - 3'd1));

    load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .rdata    (rdata_q),
        .size     (size_q),
        .zero_ext (uns_q),
        .result   (ext_rdata)
    );

    // Request capture happens only in IDLE, where the handshake is always accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= (req_size == SZ_ILLEGAL);
                        idx_q   <= '0;
                        rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q[{idx_q, 3'b000} +: 8] <= mem_rd;
                    end
                    idx_q <= idx_q + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Reset masks the handshake and side-effecting outputs in the same cycle.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_a     = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = (req_size == SZ_ILLEGAL) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_a  = addr_q + ADDR_W'(idx_q);
                mem_we = we_q;
                if (we_q) begin
                    mem_wd = wdata_q[{idx_q, 3'b000} +: 8];
                end
                if (last_byte) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? '0 : ext_rdata;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            mem_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_access_seq.sv
// Self-checking bench for dmem_access_seq with a behavioural 256x8 memory
// and a response scoreboard.
module tb_dmem_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  mem_a;
    logic [7:0]  mem_wd;
    logic        mem_we;
    logic [7:0]  mem_rd;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int we_cycles = 0;

    logic [7:0] mem [256] = '{default: 8'h00};

    dmem_access_seq #(
        .ADDR_W(8),
        .XLEN  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
    end

    always @(posedge clk) begin
        if (req_valid && req_ready) hs_count <= hs_count + 1;
        if (mem_we) we_cycles <= we_cycles + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    // Drives one request, pushes its expected response and compares when it appears.
    task automatic run_req(input string name, input logic we, input logic [1:0] size,
                           input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input int exp_lat, input int exp_we);
        int   we0;
        bit   got;
        exp_t e;
        logic [7:0] ea;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s ready: got %0b expected 1", name, req_ready);
        end
        @(posedge clk);
        we0 = we_cycles;
        sb.push_back('{exp_err, exp_rdata, exp_lat});
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        got = 1'b0;
        for (int k = 1; k <= 12 && !got; k++) begin
            if (k > 1) begin
                @(negedge clk);
                #1;
            end
            if (k < exp_lat) begin
                ea = addr + 8'(k - 1);
                n_checks++;
                if (mem_a !== ea) begin
                    n_fail++;
                    $display("[TB] FAIL %s mem_a[%0d]: got %02h expected %02h", name, k, mem_a, ea);
                end
            end
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                e = sb.pop_front();
                n_checks++;
                if (rsp_err !== e.err) begin
                    n_fail++;
                    $display("[TB] FAIL %s rsp_err: got %0b expected %0b", name, rsp_err, e.err);
                end
                n_checks++;
                if (rsp_rdata !== e.rdata) begin
                    n_fail++;
                    $display("[TB] FAIL %s rsp_rdata: got %08h expected %08h", name, rsp_rdata, e.rdata);
                end
                n_checks++;
                if (k != e.lat) begin
                    n_fail++;
                    $display("[TB] FAIL %s latency: got %0d expected %0d", name, k, e.lat);
                end
                check_bit({name, " ready_in_resp"}, req_ready, 1'b0);
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s timeout: got no response expected one", name);
            void'(sb.pop_front());
        end
        @(negedge clk);
        #1;
        check_bit({name, " ready_after"}, req_ready, 1'b1);
        n_checks++;
        if (we_cycles - we0 != exp_we) begin
            n_fail++;
            $display("[TB] FAIL %s write_cycles: got %0d expected %0d", name, we_cycles - we0, exp_we);
        end
    endtask

    task automatic check_mem(input string name, input logic [7:0] a, input logic [7:0] exp);
        n_checks++;
        if (mem[a] !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s mem[%02h]: got %02h expected %02h", name, a, mem[a], exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 8'h00; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_bit("reset ready", req_ready, 1'b0);
        check_bit("reset rsp_valid", rsp_valid, 1'b0);
        check_bit("reset mem_we", mem_we, 1'b0);
        n_checks++;
        if (rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset rsp_rdata: got %08h expected 0", rsp_rdata);
        end
        rst = 1'b0;
        #1;
        check_bit("post-reset ready", req_ready, 1'b1);
        n_checks++;
        if (mem_a !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL post-reset mem_a: got %02h expected 00", mem_a);
        end
    endtask

    task automatic test_word_store_load();
        run_req("SW 10", 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 5, 4);
        check_mem("SW", 8'h10, 8'hEF);
        check_mem("SW", 8'h11, 8'hBE);
        check_mem("SW", 8'h12, 8'hAD);
        check_mem("SW", 8'h13, 8'hDE);
        run_req("LW 10", 1'b0, 2'b10, 1'b1, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 5, 0);
    endtask

    task automatic test_sub_word_loads();
        run_req("LB 10", 1'b0, 2'b00, 1'b0, 8'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 2, 0);
        run_req("LBU 10", 1'b0, 2'b00, 1'b1, 8'h10, 32'h0, 1'b0, 32'h000000EF, 2, 0);
        run_req("LH 12", 1'b0, 2'b01, 1'b0, 8'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 3, 0);
        run_req("LHU 12", 1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 1'b0, 32'h0000DEAD, 3, 0);
        run_req("SB 20", 1'b1, 2'b00, 1'b1, 8'h20, 32'h00000077, 1'b0, 32'h0, 2, 1);
        check_mem("SB", 8'h20, 8'h77);
        check_mem("SB", 8'h21, 8'h00);
    endtask

    task automatic test_wrap();
        run_req("SH FF", 1'b1, 2'b01, 1'b0, 8'hFF, 32'h00001234, 1'b0, 32'h0, 3, 2);
        check_mem("SH wrap", 8'hFF, 8'h34);
        check_mem("SH wrap", 8'h00, 8'h12);
        run_req("LHU FF", 1'b0, 2'b01, 1'b1, 8'hFF, 32'h0, 1'b0, 32'h00001234, 3, 0);
    endtask

    task automatic test_illegal_size();
        run_req("illegal", 1'b1, 2'b11, 1'b0, 8'h30, 32'hFFFFFFFF, 1'b1, 32'h0, 1, 0);
        check_mem("illegal", 8'h30, 8'h00);
    endtask

    task automatic test_reset_mid_store();
        bit saw_rsp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 8'h40; req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check_bit("abort first we", mem_we, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_bit("abort we in rst", mem_we, 1'b0);
        check_bit("abort ready in rst", req_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("abort ready after rst", req_ready, 1'b1);
        saw_rsp = rsp_valid === 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid === 1'b1) saw_rsp = 1'b1;
        end
        check_bit("abort no response", saw_rsp, 1'b0);
        check_mem("abort", 8'h40, 8'hA5);
        check_mem("abort", 8'h41, 8'hA5);
        check_mem("abort", 8'h42, 8'h00);
        check_mem("abort", 8'h43, 8'h00);
    endtask

    task automatic test_back_to_back();
        int   hs0;
        int   k2;
        int   nrsp;
        int   rsp_k [2];
        exp_t e;
        hs0 = hs_count;
        k2 = 0;
        nrsp = 0;
        rsp_k[0] = 0;
        rsp_k[1] = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 8'h10; req_wdata = 32'h0;
        sb.push_back('{1'b0, 32'hDEADBEEF, 5});
        sb.push_back('{1'b0, 32'hDEADBEEF, 11});
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            if (req_valid && (hs_count - hs0 == 2)) begin
                req_valid = 1'b0;
                k2 = k;
            end
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL b2b extra response: got response %0d expected none", nrsp + 1);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        n_fail++;
                        $display("[TB] FAIL b2b rsp %0d: got %08h/%0b expected %08h/%0b",
                                 nrsp, rsp_rdata, rsp_err, e.rdata, e.err);
                    end
                    n_checks++;
                    if (k != e.lat) begin
                        n_fail++;
                        $display("[TB] FAIL b2b latency %0d: got %0d expected %0d", nrsp, k, e.lat);
                    end
                    check_bit("b2b ready in resp", req_ready, 1'b0);
                end
                if (nrsp < 2) rsp_k[nrsp] = k;
                nrsp++;
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (k2 != 7) begin
            n_fail++;
            $display("[TB] FAIL b2b second handshake: got cycle %0d expected 7", k2);
        end
        n_checks++;
        if (nrsp != 2) begin
            n_fail++;
            $display("[TB] FAIL b2b responses: got %0d expected 2 (at %0d,%0d)", nrsp, rsp_k[0], rsp_k[1]);
        end
        n_checks++;
        if (hs_count - hs0 != 2) begin
            n_fail++;
            $display("[TB] FAIL b2b handshakes: got %0d expected 2", hs_count - hs0);
        end
        while (sb.size() > 0) void'(sb.pop_front());
    endtask

    initial begin
        $display("[TB] starting dmem_access_seq bench");
        test_reset();
        test_word_store_load();
        test_sub_word_loads();
        test_wrap();
        test_illegal_size();
        test_reset_mid_store();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
